// File: rtl/nexys_multibot_if.sv
// KCPSM6 port-space bridge for NUM_BOTS BotSim instances: board I/O, bot select,
// per-bot motor control, coherent status snapshots and a maskable W1C interrupt.
module nexys_multibot_if #(
  parameter int NUM_BOTS      = 2,
  parameter int BSEL_W        = 3,
  parameter int LED_HI_MIRROR = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            port_id,
  input  logic [7:0]            out_port,
  output logic [7:0]            in_port,
  input  logic                  write_strobe,
  input  logic                  k_write_strobe,
  input  logic                  read_strobe,
  output logic                  interrupt,
  input  logic                  interrupt_ack,
  input  logic [5:0]            db_btns,
  input  logic [15:0]           db_sw,
  output logic [39:0]           dig,
  output logic [7:0]            dp,
  output logic [15:0]           led,
  output logic [8*NUM_BOTS-1:0] MotCtl,
  input  logic [8*NUM_BOTS-1:0] LocX,
  input  logic [8*NUM_BOTS-1:0] LocY,
  input  logic [8*NUM_BOTS-1:0] Sensors,
  input  logic [8*NUM_BOTS-1:0] botInfo,
  input  logic [8*NUM_BOTS-1:0] lmdist,
  input  logic [8*NUM_BOTS-1:0] rmdist,
  input  logic [NUM_BOTS-1:0]   upd_sysregs
);

  logic                         wr, bsel_ok, trig;
  logic [7:0]                   in_port_q, in_port_d;
  logic [15:0]                  led_q, led_d;
  logic [7:0][4:0]              dig_q, dig_d;
  logic [7:0]                   dp_q, dp_d;
  logic [BSEL_W-1:0]            bsel_q, bsel_d;
  logic [NUM_BOTS-1:0][7:0]     mot_q, mot_d;
  logic [NUM_BOTS-1:0][5:0][7:0] snap_q, snap_d;
  logic [NUM_BOTS-1:0]          mask_q, mask_d, status_q, status_d, w1c, bsel_hit;
  logic                         irq_q, irq_d, defer_q, defer_d;
  logic [2:0]                   dig_idx;
  logic [7:0]                   sel_mot;
  logic [5:0][7:0]              sel_snap;
  logic                         unused_ok;

  assign wr        = write_strobe | k_write_strobe;
  assign unused_ok = &{1'b0, read_strobe, db_btns[0]};
  // 0x03..0x06 -> digits 3..0, 0x13..0x16 -> digits 7..4
  assign dig_idx   = (3'd6 - port_id[2:0]) | {port_id[4], 2'b00};

  always_comb begin
    bsel_hit = '0;
    sel_mot  = '0;
    sel_snap = '0;
    for (int i = 0; i < NUM_BOTS; i++) begin
      if (int'(bsel_q) == i) begin
        bsel_hit[i] = 1'b1;
        sel_mot     = mot_q[i];
        sel_snap    = snap_q[i];
      end
    end
  end
  assign bsel_ok = |bsel_hit;

  always_comb begin
    led_d  = led_q;
    dig_d  = dig_q;
    dp_d   = dp_q;
    bsel_d = bsel_q;
    mot_d  = mot_q;
    mask_d = mask_q;
    w1c    = '0;
    if (wr) begin
      case (port_id)
        8'h02: led_d[7:0] = out_port;
        8'h12: if (LED_HI_MIRROR == 0) led_d[15:8] = out_port;
        8'h03, 8'h04, 8'h05, 8'h06,
        8'h13, 8'h14, 8'h15, 8'h16: dig_d[dig_idx] = out_port[4:0];
        8'h07: dp_d[3:0] = out_port[3:0];
        8'h17: dp_d[7:4] = out_port[3:0];
        8'h08: bsel_d = out_port[BSEL_W-1:0];
        8'h09: if (bsel_ok) begin
          for (int i = 0; i < NUM_BOTS; i++)
            if (bsel_hit[i]) mot_d[i] = out_port;
          if (LED_HI_MIRROR != 0) led_d[15:8] = out_port;
        end
        8'h18: w1c = out_port[NUM_BOTS-1:0];
        8'h19: mask_d = out_port[NUM_BOTS-1:0];
        default: ;
      endcase
    end
    // a same-cycle update beats the W1C
    status_d = (status_q & ~w1c) | upd_sysregs;
    snap_d   = snap_q;
    for (int i = 0; i < NUM_BOTS; i++)
      if (upd_sysregs[i])
        snap_d[i] = {rmdist[8*i +: 8], lmdist[8*i +: 8], Sensors[8*i +: 8],
                     botInfo[8*i +: 8], LocY[8*i +: 8], LocX[8*i +: 8]};
  end

  always_comb begin
    trig = (|(upd_sysregs & mask_q)) | defer_q |
           (wr && port_id == 8'h19 && (|(out_port[NUM_BOTS-1:0] & ~mask_q & status_q)));
    irq_d   = irq_q;
    defer_d = 1'b0;
    if (interrupt_ack) begin
      irq_d   = 1'b0;
      defer_d = trig;
    end else if (trig) begin
      irq_d = 1'b1;
    end
  end

  always_comb begin
    in_port_d = 8'h00;
    case (port_id)
      8'h00, 8'h10: in_port_d = {3'b000, db_btns[5:1]};
      8'h01: in_port_d = db_sw[7:0];
      8'h11: in_port_d = db_sw[15:8];
      8'h08: in_port_d = 8'(bsel_q);
      8'h09: in_port_d = sel_mot;
      8'h0A: in_port_d = sel_snap[0];
      8'h0B: in_port_d = sel_snap[1];
      8'h0C: in_port_d = sel_snap[2];
      8'h0D: in_port_d = sel_snap[3];
      8'h0E: in_port_d = sel_snap[4];
      8'h0F: in_port_d = sel_snap[5];
      8'h18: in_port_d = 8'(status_q);
      8'h19: in_port_d = 8'(mask_q);
      default: in_port_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_port_q <= '0;
      led_q     <= '0;
      dig_q     <= '0;
      dp_q      <= '0;
      bsel_q    <= '0;
      mot_q     <= '0;
      snap_q    <= '0;
      mask_q    <= '0;
      status_q  <= '0;
      irq_q     <= 1'b0;
      defer_q   <= 1'b0;
    end else begin
      in_port_q <= in_port_d;
      led_q     <= led_d;
      dig_q     <= dig_d;
      dp_q      <= dp_d;
      bsel_q    <= bsel_d;
      mot_q     <= mot_d;
      snap_q    <= snap_d;
      mask_q    <= mask_d;
      status_q  <= status_d;
      irq_q     <= irq_d;
      defer_q   <= defer_d;
    end
  end

  assign in_port   = in_port_q;
  assign led       = led_q;
  assign dig       = dig_q;
  assign dp        = dp_q;
  assign MotCtl    = mot_q;
  assign interrupt = irq_q;

endmodule

// File: doc/nexys_multibot_if.md
Name: nexys_multibot_if

Overview:
- KCPSM6 I/O-port interface that serves NUM_BOTS BotSim instances through one 8-bit port space.
- Connects to the debounced buttons/switches, the 8-digit seven-segment driver and the LEDs.
- Captures coherent per-bot snapshots of the six bot status registers on each bot's upd_sysregs pulse.
- Adds a bot-select register, per-bot motor control, and a maskable, write-1-to-clear interrupt status with lossless interrupt/ack handling.

Parameters:
- NUM_BOTS, 2: number of bots, 1..8.
- BSEL_W, 3: bot-select register width. Must satisfy 2**BSEL_W >= NUM_BOTS.
- LED_HI_MIRROR, 1: selects the source of led[15:8].
  - 1: led[15:8] mirrors every MotCtl write.
  - 0: led[15:8] is written through port 0x12.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- port_id  in  8  KCPSM6 port address
- out_port  in  8  KCPSM6 write data
- in_port  out  8  KCPSM6 read data (registered)
- write_strobe  in  1  KCPSM6 OUTPUT strobe
- k_write_strobe  in  1  KCPSM6 OUTPUTK strobe
- read_strobe  in  1  KCPSM6 INPUT strobe (unused; reads have no side effects)
- interrupt  out  1  interrupt request to KCPSM6
- interrupt_ack  in  1  KCPSM6 interrupt acknowledge
- db_btns  in  6  debounced buttons: [5]C [4]L [3]U [2]R [1]D
- db_sw  in  16  debounced slide switches
- dig  out  40  digit codes, 5 bits each; dig[5k+4:5k] = digit k, k = 0..7
- dp  out  8  decimal points
- led  out  16  LEDs
- MotCtl  out  8*NUM_BOTS  motor control; bot i at [8i+7:8i]
- LocX, LocY, Sensors, botInfo, lmdist, rmdist  in  8*NUM_BOTS each  bot status; same slicing as MotCtl
- upd_sysregs  in  NUM_BOTS  per-bot update pulse (one clk wide)

Behaviour:
- Reset (asynchronous): all outputs 0, including in_port, interrupt, dig, dp, led and MotCtl. BSEL=0, IRQ_MASK=0, IRQ_STATUS=0, deferred flag=0, all snapshots=0.
- Write qualifier: wr = write_strobe | k_write_strobe.
- Address map; R = read, W = write:
  - 0x00 and 0x10 R: {3'b0, C, L, U, R, D}
  - 0x01 R: db_sw[7:0]; 0x11 R: db_sw[15:8]
  - 0x02 W: led[7:0]
  - 0x12 W: led[15:8]; ignored when LED_HI_MIRROR=1
  - 0x03..0x06 W: digits 3..0; 0x13..0x16 W: digits 7..4. Each takes out_port[4:0].
  - 0x07 W: dp[3:0] <= out_port[3:0]; 0x17 W: dp[7:4] <= out_port[3:0]
  - 0x08 R/W: BSEL; only the low BSEL_W bits are stored, read zero-extended
  - 0x09 R/W: MotCtl of bot BSEL. When LED_HI_MIRROR=1, also led[15:8] <= out_port.
  - 0x0A..0x0F R: snapshot of bot BSEL, in order LocX, LocY, botInfo, Sensors, lmdist, rmdist
  - 0x18 R: IRQ_STATUS (bit i = bot i pending). 0x18 W: write-1-to-clear.
  - 0x19 R/W: IRQ_MASK
  - 0x1A..0x1F reserved: reads return 0, writes ignored
- Bot-status bits: IRQ_STATUS and IRQ_MASK bits at and above NUM_BOTS read 0 and are not writable.
- Out-of-range BSEL (BSEL >= NUM_BOTS): reads of 0x09..0x0F return 0; writes to 0x09 are ignored, including the LED mirror.
- Read path: in_port is registered from port_id every cycle, so latency is 1 clk. Unmapped and write-only addresses read 0x00, never X.
- Snapshot: on upd_sysregs[i], all six inputs of bot i are captured in the same clk edge. A read always returns one update's values.
- Status set/clear: upd_sysregs[i] sets IRQ_STATUS[i]. If a set and a W1C of the same bit occur in the same cycle, set wins.
- Interrupt trigger, any of:
  - upd_sysregs[i] & IRQ_MASK[i] for any i;
  - a write to 0x19 that newly enables a bit already pending;
  - the deferred flag being set.
- Interrupt output rules:
  - interrupt_ack: interrupt <= 0.
  - If a trigger coincides with ack, set the deferred flag; interrupt reasserts on the next clk and the flag clears.
  - Otherwise a trigger sets interrupt <= 1 one clk after the trigger cycle.
  - interrupt holds until acked. Clearing IRQ_STATUS does not deassert it.
- Multiple simultaneous updates set multiple status bits and produce one interrupt.

Test Plan:
- Reset mid-operation with MotCtl[bot1]=0x5A and dig=all 0x1F -> all outputs 0 immediately, with no clk edge needed; a read of 0x19 afterwards returns 0x00.
- Snapshot coherency: BSEL=1, pulse upd_sysregs[1] with LocX=0x12, LocY=0x34, then change the inputs → reads of 0x0A and 0x0B return 0x12 and 0x34 (1-clk latency). Bot 0's snapshot stays 0.
- MotCtl routing: write 0x08=1, then 0x09=0xA5 → MotCtl[15:8]=0xA5, MotCtl[7:0]=0x00, and led[15:8]=0xA5 (mirror=1). With BSEL=5: a write of 0x77 is ignored and a read of 0x09 returns 0x00.
- IRQ mask and W1C: mask=0x00, pulse upd_sysregs[0] → interrupt stays 0 and status=0x01. Write mask=0x01 → interrupt=1 next clk. Ack → 0. Write 0x18=0x01 → status=0x00.
- Ack collision: mask=0x03 with interrupt=1; ack in the same cycle as upd_sysregs[1] → interrupt 0 that edge, 1 on the next, status=0x02.
- Set/clear collision: W1C of 0x01 coincident with upd_sysregs[0] → status bit 0 remains 1. An unmapped read of 0x1C returns 0x00.
